// File: rtl/pinball_pkg.sv
// pinball_pkg: shared sizing constants for the playfield sensor logic
package pinball_pkg;
  localparam int N_HOLES = 8;
  localparam int HOLE_W = 3;
  localparam int HOLDOFF_DEFAULT = 50000;
endpackage

// File: rtl/hole_event_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search for the first request at or after ptr
module rr_pick
  import pinball_pkg::*;
#(
  parameter int N = pinball_pkg::N_HOLES
) (
  input  logic [N-1:0]      req,
  input  logic [HOLE_W-1:0] ptr,
  output logic [HOLE_W-1:0] grant_idx,
  output logic              any
);
  logic [N-1:0] rot;
  int off;
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = 0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? k : off;
    off = off + int'(ptr);
    grant_idx = HOLE_W'(off >= N ? off - N : off);
    any = |req;
  end
endmodule

// File: rtl/hole_event_arbiter.sv
// hole_event_arbiter: debounced hole hits queued as pending bits and issued round-robin
module hole_event_arbiter
  import pinball_pkg::*;
#(
  parameter int N_HOLES = pinball_pkg::N_HOLES,
  parameter int HOLDOFF_CYCLES = HOLDOFF_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               flush,
  input  logic [N_HOLES-1:0] hole_in,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [HOLE_W-1:0]  ev_hole,
  output logic [N_HOLES-1:0] pending,
  output logic [7:0]         drop_cnt
);
  logic [N_HOLES-1:0] s1, s2, prev, hit, acc, clr, drp;
  logic [2:0] warm;
  logic [15:0] hold [N_HOLES];
  logic [HOLE_W-1:0] rr_ptr, grant;
  logic [8:0] dsum;
  logic any, load;
  rr_pick #(.N(N_HOLES)) u_pick (.req(pending), .ptr(rr_ptr), .grant_idx(grant), .any(any));
  // warm masks hits until edge history has seen the filled synchronizer after reset
  assign hit = s2 & ~prev & {N_HOLES{warm[2]}};
  assign load = (~ev_valid | ev_ready) & any & ~flush;
  assign clr = load ? N_HOLES'(1) << grant : '0;
  assign drp = acc & pending & ~clr;
  always_comb begin
    dsum = {1'b0, drop_cnt};
    for (int i = 0; i < N_HOLES; i++) begin
      acc[i] = hit[i] & enable & ~flush & (hold[i] == '0);
      dsum = dsum + 9'(drp[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
      warm <= '0;
      pending <= '0;
      ev_valid <= 1'b0;
      ev_hole <= '0;
      rr_ptr <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < N_HOLES; i++) hold[i] <= '0;
    end else begin
      s1 <= hole_in;
      s2 <= s1;
      prev <= s2;
      warm <= {warm[1:0], 1'b1};
      pending <= flush ? '0 : (pending & ~clr) | acc;
      ev_valid <= ~flush & (load | (ev_valid & ~ev_ready));
      if (load) begin
        ev_hole <= grant;
        rr_ptr <= (grant == HOLE_W'(N_HOLES - 1)) ? '0 : grant + 1'b1;
      end
      drop_cnt <= dsum[8] ? 8'hFF : dsum[7:0];
      for (int i = 0; i < N_HOLES; i++)
        hold[i] <= acc[i] ? 16'(HOLDOFF_CYCLES) : (hold[i] != '0 ? hold[i] - 16'd1 : '0);
    end
  end
endmodule

// File: tb/tb_hole_event_arbiter.sv
// tb_hole_event_arbiter: scenario tasks plus a scoreboard checking every issued event
module tb_hole_event_arbiter;
  logic clk = 0, rst_n = 0, enable = 0, flush = 0, ev_ready = 0;
  logic [7:0] hole_in = '0;
  logic ev_valid;
  logic [2:0] ev_hole;
  logic [7:0] pending, drop_cnt;
  int checks = 0, errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] sb_exp;
  always #5 clk = ~clk;
  hole_event_arbiter #(.N_HOLES(8), .HOLDOFF_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush), .hole_in(hole_in),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_hole(ev_hole), .pending(pending), .drop_cnt(drop_cnt)
  );
  always @(negedge clk) begin
    if (rst_n && !flush && ev_valid && ev_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got event hole %0d, none expected", ev_hole);
      end else begin
        sb_exp = exp_q.pop_front();
        if (ev_hole !== sb_exp) begin
          errors++;
          $display("FAIL sb_hole: got %0d want %0d", ev_hole, sb_exp);
        end
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 0;
    step(3);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
    checks++; if (ev_hole !== 3'd0) begin errors++; $display("FAIL reset_hole: got %0d want 0", ev_hole); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h want 00", pending); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    rst_n = 1;
    step(4);
  endtask
  task automatic test_single;
    enable = 1; ev_ready = 1;
    exp_q.push_back(3'd2);
    hole_in = 8'h04;
    step(3);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", ev_valid); end
    checks++; if (pending !== 8'h04) begin errors++; $display("FAIL single_pend: got %h want 04", pending); end
    step(1);
    checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", ev_valid); end
    checks++; if (ev_hole !== 3'd2) begin errors++; $display("FAIL single_hole: got %0d want 2", ev_hole); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL single_pend_clr: got %h want 00", pending); end
    step(1);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_onecycle: got %b want 0", ev_valid); end
    hole_in = '0;
    step(6);
  endtask
  task automatic test_simultaneous;
    logic [2:0] seq [3];
    seq[0] = 3'd0; seq[1] = 3'd4; seq[2] = 3'd7;
    rst_n = 0;
    step(1);
    rst_n = 1;
    step(4);
    for (int i = 0; i < 3; i++) exp_q.push_back(seq[i]);
    hole_in = 8'h91;
    step(3);
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if (ev_valid !== 1'b1 || ev_hole !== seq[i]) begin errors++; $display("FAIL simul_seq%0d: got v=%b h=%0d want v=1 h=%0d", i, ev_valid, ev_hole, seq[i]); end
    end
    step(1);
    checks++; if (ev_valid !== 1'b0 || pending !== 8'h00) begin errors++; $display("FAIL simul_end: got v=%b p=%h want v=0 p=00", ev_valid, pending); end
    hole_in = '0;
    step(6);
  endtask
  task automatic test_backpressure;
    ev_ready = 0;
    exp_q.push_back(3'd1); exp_q.push_back(3'd3);
    hole_in = 8'h0A;
    step(4);
    hole_in = '0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ev_valid !== 1'b1 || ev_hole !== 3'd1) begin errors++; $display("FAIL bp_hold%0d: got v=%b h=%0d want v=1 h=1", i, ev_valid, ev_hole); end
      step(1);
    end
    ev_ready = 1;
    step(1);
    ev_ready = 0;
    checks++; if (ev_valid !== 1'b1 || ev_hole !== 3'd3) begin errors++; $display("FAIL bp_second: got v=%b h=%0d want v=1 h=3", ev_valid, ev_hole); end
    step(2);
    checks++; if (ev_valid !== 1'b1 || ev_hole !== 3'd3) begin errors++; $display("FAIL bp_second_hold: got v=%b h=%0d want v=1 h=3", ev_valid, ev_hole); end
    ev_ready = 1;
    step(1);
    ev_ready = 0;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", ev_valid); end
    step(6);
  endtask
  task automatic test_drop_holdoff;
    ev_ready = 0;
    exp_q.push_back(3'd5);
    for (int p = 0; p < 3; p++) begin
      hole_in = 8'h20;
      step(1);
      hole_in = '0;
      step(5);
    end
    step(3);
    checks++; if (ev_valid !== 1'b1 || ev_hole !== 3'd5) begin errors++; $display("FAIL drop_event: got v=%b h=%0d want v=1 h=5", ev_valid, ev_hole); end
    checks++; if (pending !== 8'h20) begin errors++; $display("FAIL drop_pending: got %h want 20", pending); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt: got %0d want 1", drop_cnt); end
    exp_q.push_back(3'd5);
    ev_ready = 1;
    step(1);
    checks++; if (ev_valid !== 1'b1 || pending !== 8'h00) begin errors++; $display("FAIL drop_reload: got v=%b p=%h want v=1 p=00", ev_valid, pending); end
    step(1);
    ev_ready = 0;
    step(4);
    exp_q.push_back(3'd5);
    hole_in = 8'h20;
    step(1);
    hole_in = '0;
    step(1);
    hole_in = 8'h20;
    step(1);
    hole_in = '0;
    step(6);
    checks++; if (ev_valid !== 1'b1 || pending !== 8'h00) begin errors++; $display("FAIL holdoff_ignore: got v=%b p=%h want v=1 p=00", ev_valid, pending); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL holdoff_nodrop: got %0d want 1", drop_cnt); end
    ev_ready = 1;
    step(1);
    ev_ready = 0;
    step(6);
  endtask
  task automatic test_gating_flush;
    enable = 0;
    hole_in = 8'h01;
    step(1);
    hole_in = '0;
    step(5);
    checks++; if (pending !== 8'h00 || ev_valid !== 1'b0) begin errors++; $display("FAIL gate: got p=%h v=%b want p=00 v=0", pending, ev_valid); end
    enable = 1;
    hole_in = 8'h41;
    step(1);
    hole_in = '0;
    step(2);
    checks++; if (pending !== 8'h41) begin errors++; $display("FAIL flush_pre_pend: got %h want 41", pending); end
    step(1);
    checks++; if (ev_valid !== 1'b1 || ev_hole !== 3'd6) begin errors++; $display("FAIL flush_pre_ev: got v=%b h=%0d want v=1 h=6", ev_valid, ev_hole); end
    flush = 1;
    step(1);
    flush = 0;
    checks++; if (pending !== 8'h00 || ev_valid !== 1'b0) begin errors++; $display("FAIL flush_clr: got p=%h v=%b want p=00 v=0", pending, ev_valid); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL flush_drop: got %0d want 1", drop_cnt); end
    ev_ready = 1;
    step(4);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL flush_after: got %b want 0", ev_valid); end
    ev_ready = 0;
  endtask
  task automatic test_reset_mid;
    logic seen;
    hole_in = 8'h0E;
    step(4);
    checks++; if (ev_valid !== 1'b1 || ev_hole !== 3'd1 || pending !== 8'h0C) begin errors++; $display("FAIL rstmid_pre: got v=%b h=%0d p=%h want v=1 h=1 p=0c", ev_valid, ev_hole, pending); end
    hole_in = 8'hFF;
    ev_ready = 1;
    rst_n = 0;
    step(1);
    checks++; if (ev_valid !== 1'b0 || ev_hole !== 3'd0 || pending !== 8'h00 || drop_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_clr: got v=%b h=%0d p=%h d=%0d want all 0", ev_valid, ev_hole, pending, drop_cnt); end
    step(1);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      seen = seen | ev_valid | (|pending);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_noevent: got %b want 0", seen); end
    hole_in = 8'hF7;
    step(1);
    hole_in = 8'hFF;
    exp_q.push_back(3'd3);
    step(6);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_rearm: got %0d outstanding want 0", exp_q.size()); end
    ev_ready = 0;
  endtask
  initial begin
    test_reset;
    test_single;
    test_simultaneous;
    test_backpressure;
    test_drop_holdoff;
    test_gating_flush;
    test_reset_mid;
    step(2);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d outstanding want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hole_event_arbiter.md
HOLE_EVENT_ARBITER -- requirements
Module: hole_event_arbiter

Interface
REQ-001 Parameter N_HOLES, default 8: number of hole sensors.
REQ-002 Parameter HOLDOFF_CYCLES, default 50000: per-hole re-trigger lockout, in clk cycles.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 enable  in  1  high while the game is in play (START/GET); gates capture of new hits.
REQ-006 flush  in  1  synchronous clear of pending hits and of the output event.
REQ-007 hole_in  in  N_HOLES  raw, asynchronous hole sensor levels; bit i = hole i.
REQ-008 ev_valid  out  1  output event present.
REQ-009 ev_ready  in  1  consumer (scoring unit) accepts the event.
REQ-010 ev_hole  out  3  index of the hole for the current event.
REQ-011 pending  out  N_HOLES  hits captured but not yet issued.
REQ-012 drop_cnt  out  8  saturating count of hits lost because that hole was already pending.

Function
REQ-013 Each hole_in bit SHALL pass a 2-flop synchronizer; a hit is a 0->1 transition of the synchronized level.
REQ-014 A hit on hole i SHALL be accepted only if enable=1 and holdoff counter i = 0; otherwise it is ignored and not counted.
REQ-015 Accepting a hit SHALL load holdoff counter i with HOLDOFF_CYCLES; the counter decrements by 1 per cycle to 0 and holds at 0.
REQ-016 An accepted hit SHALL set pending[i] on the next edge; if pending[i] is already 1 and not being cleared that cycle, drop_cnt increments instead (saturating at 255).
REQ-017 If a hit on hole i coincides with pending[i] being cleared by issue, set wins: pending[i] stays 1 and drop_cnt does not change.
REQ-018 Output register SHALL load when (ev_valid=0 or ev_ready=1) and pending != 0; the grant is the first set bit at or after rr_ptr, wrapping at N_HOLES-1 -> 0.
REQ-019 On load: ev_hole = granted index, ev_valid = 1, pending[granted] cleared, rr_ptr = granted+1 mod N_HOLES.
REQ-020 ev_valid/ev_hole SHALL hold stable until ev_ready=1 is sampled; when ev_ready=1 and nothing is pending, ev_valid drops on that edge.
REQ-021 Throughput is 1 event per cycle while ev_ready=1.
REQ-022 Latency: hole_in first sampled high at edge 0 on an idle block -> ev_valid=1 after edge 3.
REQ-023 enable=0 SHALL NOT clear pending; already-captured hits continue to drain.
REQ-024 flush=1 SHALL clear pending and ev_valid on the next edge, and SHALL suppress any capture and load that cycle; holdoff counters, rr_ptr and drop_cnt are unaffected.

Reset
REQ-025 rst_n=0 at an edge SHALL clear synchronizer flops, edge history, pending, holdoff counters, ev_valid, ev_hole, rr_ptr and drop_cnt to 0, overriding all other inputs, including mid-handshake.
REQ-026 The first cycle after reset SHALL NOT report a hit for a hole_in bit that was already high during reset; edge history resets to 0 and synchronizer flops fill first.

Structure
REQ-027 N_HOLES, hole index width (3) and the HOLDOFF_CYCLES default SHALL live in shared package pinball_pkg.
REQ-028 The round-robin search SHALL be a combinational sub-module rr_pick, with inputs req[N_HOLES] and ptr, and outputs grant_idx and any.
REQ-029 Holdoff counters SHALL be 16 bits wide (HOLDOFF_CYCLES <= 65535).

Verification
REQ-030 Single hit: enable=1, ev_ready=1, hole_in=0x04 -> ev_valid high after edge 3, ev_hole=2 for exactly 1 cycle, pending=0.
REQ-031 Simultaneous hits: hole_in 0x00->0x91 in one cycle, ev_ready=1, rr_ptr=0 -> ev_hole sequence 0, 4, 7 on consecutive cycles.
REQ-032 Backpressure: ev_ready=0 with hits on holes 1 and 3 -> ev_hole=1 held stable; ev_ready pulses -> 3, then ev_valid=0.
REQ-033 Drop and holdoff: HOLDOFF_CYCLES=4, ev_ready=0, hole 5 pulsed every 6 cycles three times -> 1 event outstanding, pending[5]=1, drop_cnt=1; a pulse 2 cycles after an accepted one is ignored with no drop.
REQ-034 Gating and flush: enable=0 with hit on hole 0 -> no pending; enable=1 with hits 0 and 6, then flush -> pending=0, ev_valid=0, drop_cnt unchanged.
REQ-035 Reset mid-operation: rst_n=0 while ev_valid=1 and pending=0x0C with hole_in=0xFF held -> all outputs 0; no event after release until some hole_in bit falls and rises again.
